// File: rtl/sap_1_pkg.sv
// sap_1_pkg: shared constants for the SAP-1 controller/sequencer.
//   - opcode encodings (upper nibble of the instruction register)
//   - idle control word and bit positions inside the 12-bit Con word
//   - ring-counter bit positions (T1..T6)
//   - opcode classification helper used by the decoder
package sap_1_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // All loads/enables inactive, Su=0, Eu=0.
    localparam logic [11:0] CON_IDLE = 12'h3E3;

    localparam int unsigned CON_CP   = 11;
    localparam int unsigned CON_EP   = 10;
    localparam int unsigned CON_LM_N = 9;
    localparam int unsigned CON_CE_N = 8;
    localparam int unsigned CON_LI_N = 7;
    localparam int unsigned CON_EI_N = 6;
    localparam int unsigned CON_LA_N = 5;
    localparam int unsigned CON_EA   = 4;
    localparam int unsigned CON_SU   = 3;
    localparam int unsigned CON_EU   = 2;
    localparam int unsigned CON_LB_N = 1;
    localparam int unsigned CON_LO_N = 0;

    localparam int unsigned T1_IDX = 0;
    localparam int unsigned T2_IDX = 1;
    localparam int unsigned T3_IDX = 2;
    localparam int unsigned T4_IDX = 3;
    localparam int unsigned T5_IDX = 4;
    localparam int unsigned T6_IDX = 5;

    typedef enum logic [2:0] {
        OPK_NOP,
        OPK_LDA,
        OPK_ADD,
        OPK_SUB,
        OPK_OUT,
        OPK_HLT
    } op_kind_t;

    // Undefined opcodes fold into NOP or HLT depending on the instance setting.
    function automatic op_kind_t classify(input logic [3:0] opcode, input logic halt_on_unknown);
        op_kind_t k;
        case (opcode)
            OP_LDA:  k = OPK_LDA;
            OP_ADD:  k = OPK_ADD;
            OP_SUB:  k = OPK_SUB;
            OP_OUT:  k = OPK_OUT;
            OP_HLT:  k = OPK_HLT;
            default: k = halt_on_unknown ? OPK_HLT : OPK_NOP;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/SAP_1_ring_counter.sv
// SAP_1_ring_counter: six-state one-hot timing ring T1->T2->...->T6->T1.
// Ports:
//   Clk     - system clock, state advances on rising edge
//   Clr_n   - asynchronous active-low reset, forces T1
//   hold    - freeze the current state (takes priority over restart)
//   restart - jump back to T1 on the next edge instead of advancing
//   T_state - one-hot state, bit0 = T1 ... bit5 = T6
module SAP_1_ring_counter (
    input  logic       Clk,
    input  logic       Clr_n,
    input  logic       hold,
    input  logic       restart,
    output logic [5:0] T_state
);

    typedef enum logic [5:0] {
        S_T1 = 6'b000001,
        S_T2 = 6'b000010,
        S_T3 = 6'b000100,
        S_T4 = 6'b001000,
        S_T5 = 6'b010000,
        S_T6 = 6'b100000
    } ring_t;

    ring_t state_q, state_d;

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) state_q <= S_T1;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (hold) begin
            state_d = state_q;
        end else if (restart) begin
            state_d = S_T1;
        end else begin
            case (state_q)
                S_T1:    state_d = S_T2;
                S_T2:    state_d = S_T3;
                S_T3:    state_d = S_T4;
                S_T4:    state_d = S_T5;
                S_T5:    state_d = S_T6;
                S_T6:    state_d = S_T1;
                default: state_d = S_T1;
            endcase
        end
    end

    assign T_state = state_q;

endmodule

// File: rtl/sap_1_controller_sequencer.sv
// sap_1_controller_sequencer: SAP-1 control unit. Drives the 12-bit control
// word combinationally from the ring-counter state and the current opcode.
// Parameter:
//   HALT_ON_UNKNOWN - undefined opcode behaves as NOP (0) or HLT (1)
// Ports:
//   Clk     - system clock
//   Clr_n   - asynchronous active-low reset
//   Opcode  - upper nibble of the instruction register
//   Con     - control word {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
//   T_state - one-hot timing state, bit0 = T1 ... bit5 = T6
//   Halt    - high once HLT has executed; cleared only by Clr_n
// Build option:
//   SAP_1_SKIP_NOP_STATES_EN - return to T1 right after the last non-idle
//                              state of each instruction instead of always
//                              walking the full six-state ring.
module sap_1_controller_sequencer
    import sap_1_pkg::*;
#(
    parameter logic HALT_ON_UNKNOWN = 1'b0
) (
    input  logic        Clk,
    input  logic        Clr_n,
    input  logic [3:0]  Opcode,
    output logic [11:0] Con,
    output logic [5:0]  T_state,
    output logic        Halt
);

    op_kind_t    kind;
    logic        halt_q;
    logic        restart;
    logic [11:0] con_d;

    assign kind = classify(Opcode, HALT_ON_UNKNOWN);

    // HLT is taken on the edge that ends T3; the ring then sits at T4.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n)                            halt_q <= 1'b0;
        else if (T_state[T3_IDX] && kind == OPK_HLT) halt_q <= 1'b1;
    end

`ifdef SAP_1_SKIP_NOP_STATES_EN
    assign restart = (T_state[T3_IDX] && kind == OPK_NOP) ||
                     (T_state[T4_IDX] && kind == OPK_OUT) ||
                     (T_state[T5_IDX] && kind == OPK_LDA);
`else
    assign restart = 1'b0;
`endif

    SAP_1_ring_counter u_ring (
        .Clk     (Clk),
        .Clr_n   (Clr_n),
        .hold    (halt_q),
        .restart (restart),
        .T_state (T_state)
    );

    always_comb begin
        con_d = CON_IDLE;
        if (!halt_q) begin
            if (T_state[T1_IDX]) begin
                con_d[CON_EP]   = 1'b1;
                con_d[CON_LM_N] = 1'b0;
            end else if (T_state[T2_IDX]) begin
                con_d[CON_CP]   = 1'b1;
            end else if (T_state[T3_IDX]) begin
                con_d[CON_CE_N] = 1'b0;
                con_d[CON_LI_N] = 1'b0;
            end else if (T_state[T4_IDX]) begin
                case (kind)
                    OPK_LDA, OPK_ADD, OPK_SUB: begin
                        con_d[CON_EI_N] = 1'b0;
                        con_d[CON_LM_N] = 1'b0;
                    end
                    OPK_OUT: begin
                        con_d[CON_EA]   = 1'b1;
                        con_d[CON_LO_N] = 1'b0;
                    end
                    default: ;
                endcase
            end else if (T_state[T5_IDX]) begin
                case (kind)
                    OPK_LDA: begin
                        con_d[CON_CE_N] = 1'b0;
                        con_d[CON_LA_N] = 1'b0;
                    end
                    OPK_ADD, OPK_SUB: begin
                        con_d[CON_CE_N] = 1'b0;
                        con_d[CON_LB_N] = 1'b0;
                    end
                    default: ;
                endcase
            end else if (T_state[T6_IDX]) begin
                if (kind == OPK_ADD || kind == OPK_SUB) begin
                    con_d[CON_LA_N] = 1'b0;
                    con_d[CON_EU]   = 1'b1;
                    con_d[CON_SU]   = (kind == OPK_SUB);
                end
            end
        end
    end

    assign Con  = con_d;
    assign Halt = halt_q;

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// tb_sap_1_controller_sequencer: scoreboard bench for the SAP-1 controller.
// Two instances (HALT_ON_UNKNOWN = 0 and 1) share clock, reset and opcode.
// A driver pushes the expected T_state/Con/Halt for every cycle into a queue;
// a monitor on the falling edge pops and compares.
module tb_sap_1_controller_sequencer;

    logic        Clk = 1'b0;
    logic        Clr_n;
    logic [3:0]  Opcode;
    logic [11:0] con0, con1;
    logic [5:0]  t0, t1;
    logic        halt0, halt1;

    always #5 Clk = ~Clk;

    sap_1_controller_sequencer #(.HALT_ON_UNKNOWN(1'b0)) dut0 (
        .Clk(Clk), .Clr_n(Clr_n), .Opcode(Opcode),
        .Con(con0), .T_state(t0), .Halt(halt0)
    );

    sap_1_controller_sequencer #(.HALT_ON_UNKNOWN(1'b1)) dut1 (
        .Clk(Clk), .Clr_n(Clr_n), .Opcode(Opcode),
        .Con(con1), .T_state(t1), .Halt(halt1)
    );

`ifdef SAP_1_SKIP_NOP_STATES_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    localparam int K_NOP = 0, K_LDA = 1, K_ADD = 2, K_SUB = 3, K_OUT = 4, K_HLT = 5;

    typedef struct {
        int unsigned dut;
        logic [5:0]  t;
        logic [11:0] con;
        logic        halt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: current step (1..6) and halted flag per instance.
    int         p[2];
    bit         h[2];
    bit         prev_rst;
    logic [3:0] prev_op;
    logic [3:0] cur_op;
    bit         rand_mode;

    function automatic int kind_of(input logic [3:0] op, input bit hou);
        case (op)
            4'b0000: return K_LDA;
            4'b0001: return K_ADD;
            4'b0010: return K_SUB;
            4'b1110: return K_OUT;
            4'b1111: return K_HLT;
            default: return hou ? K_HLT : K_NOP;
        endcase
    endfunction

    // Step after which the instruction is finished.
    function automatic int last_step(input int k);
        if (!SKIP) return 6;
        case (k)
            K_LDA:   return 5;
            K_OUT:   return 4;
            K_NOP:   return 3;
            default: return 6;
        endcase
    endfunction

    // Microcode table expressed as "which signals are active" per step.
    function automatic logic [11:0] ref_con(input int step, input bit halted,
                                            input logic [3:0] op, input bit hou);
        bit cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
        int k;
        {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = '0;
        k = kind_of(op, hou);
        if (!halted) begin
            case (step)
                1: begin ep = 1; lm = 1; end
                2: cp = 1;
                3: begin ce = 1; li = 1; end
                4: if (k == K_LDA || k == K_ADD || k == K_SUB) begin ei = 1; lm = 1; end
                   else if (k == K_OUT) begin ea = 1; lo = 1; end
                5: if (k == K_LDA) begin ce = 1; la = 1; end
                   else if (k == K_ADD || k == K_SUB) begin ce = 1; lb = 1; end
                6: if (k == K_ADD || k == K_SUB) begin la = 1; eu = 1; su = (k == K_SUB); end
                default: ;
            endcase
        end
        return {cp, ep, ~lm, ~ce, ~li, ~ei, ~la, ea, su, eu, ~lb, ~lo};
    endfunction

    function automatic logic [3:0] pick_op();
        case ($urandom_range(0, 9))
            0, 1:    return 4'b0000;
            2, 3:    return 4'b0001;
            4, 5:    return 4'b0010;
            6, 7:    return 4'b1110;
            8:       return 4'b1111;
            default: return 4'($urandom);
        endcase
    endfunction

    // One clock cycle: advance the model across the edge, drive new inputs,
    // push the expected outputs for this cycle.
    task automatic cyc(input bit rst_req);
        logic [3:0] op;
        int k;
        exp_t e;
        @(posedge Clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            k = kind_of(prev_op, d == 1);
            if (prev_rst) begin
                p[d] = 1; h[d] = 0;
            end else if (h[d]) begin
            end else if (p[d] == 3 && k == K_HLT) begin
                p[d] = 4; h[d] = 1;
            end else if (p[d] == last_step(k)) begin
                p[d] = 1;
            end else begin
                p[d] = p[d] + 1;
            end
        end
        if (rand_mode && p[0] == 1) cur_op = pick_op();
        // Opcode is only meaningful from T3 on; before that drive noise.
        op = (p[0] >= 3) ? cur_op : 4'($urandom);
        Opcode = op;
        Clr_n  = ~rst_req;
        for (int d = 0; d < 2; d++) begin
            e.dut = d;
            if (rst_req) begin
                e.t = 6'b000001; e.halt = 1'b0; e.con = ref_con(1, 0, op, d == 1);
            end else begin
                e.t = 6'(1 << (p[d] - 1)); e.halt = h[d]; e.con = ref_con(p[d], h[d], op, d == 1);
            end
            sb.push_back(e);
        end
        prev_op  = op;
        prev_rst = rst_req;
    endtask

    task automatic chk(input string name, input int unsigned d,
                       input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        while (sb.size() > 0) begin
            logic [11:0] ac;
            logic [5:0]  at;
            logic        ah;
            int          drivers;
            mon_e = sb.pop_front();
            ac = mon_e.dut == 1 ? con1  : con0;
            at = mon_e.dut == 1 ? t1    : t0;
            ah = mon_e.dut == 1 ? halt1 : halt0;
            chk("T_state", mon_e.dut, {6'b0, at}, {6'b0, mon_e.t});
            chk("Con", mon_e.dut, ac, mon_e.con);
            chk("Halt", mon_e.dut, {11'b0, ah}, {11'b0, mon_e.halt});
            chk("su_needs_eu_la", mon_e.dut,
                {11'b0, ~ac[3] | (ac[2] & ~ac[5])}, 12'd1);
            drivers = int'(ac[10]) + int'(~ac[6]) + int'(~ac[8]) + int'(ac[4]) + int'(ac[2]);
            chk("single_bus_driver", mon_e.dut, {11'b0, drivers <= 1}, 12'd1);
        end
    end

    initial begin
        Clr_n = 1'b0; Opcode = '0;
        p[0] = 1; p[1] = 1; h[0] = 0; h[1] = 0;
        prev_rst = 1'b1; prev_op = '0; cur_op = '0; rand_mode = 1'b0;

        cyc(1); cyc(1);
        // SUB through T6 and back to T1
        cur_op = 4'b0010; repeat (7) cyc(0);
        // LDA then OUT
        cur_op = 4'b0000; repeat (6) cyc(0);
        cur_op = 4'b1110; repeat (6) cyc(0);
        // HLT: halted at T4 for 10 cycles, then reset and resume
        cyc(1);
        cur_op = 4'b1111; repeat (13) cyc(0);
        cyc(1); repeat (3) cyc(0);
        // Reset asserted in the middle of T5 of an ADD
        cur_op = 4'b0001; cyc(1); repeat (4) cyc(0); cyc(1); repeat (7) cyc(0);
        // Undefined opcode: NOP on dut0, HLT on dut1
        cyc(1); cur_op = 4'b0101; repeat (8) cyc(0); cyc(1);
        // Randomized instruction stream with occasional resets
        rand_mode = 1'b1;
        repeat (400) begin
            if (h[0] || h[1]) cyc($urandom_range(0, 3) == 0);
            else              cyc($urandom_range(0, 49) == 0);
        end

        @(negedge Clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
